// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// 3-sample majority voting per bit, valid/ready output with parity/framing/overrun reporting.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned UART_BPS  = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam logic [15:0] BIT_CYC   = 16'(CLK_FREQ / UART_BPS);
    localparam logic [15:0] HALF      = BIT_CYC / 16'd2;
    localparam logic [15:0] SAMP_A    = HALF - 16'd1;
    localparam logic [15:0] SAMP_C    = HALF + 16'd1;
    localparam logic [15:0] CNT_LAST  = BIT_CYC - 16'd1;
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 sync1_q, sync2_q, prev_q;
    logic [2:0]           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 operr_q, operr_d, oferr_q, oferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q;

    logic maj, at_a, at_b, at_c, at_end, exp_par, done, frame_ferr;

    // Third sample is the live synced value at HALF+1
    assign maj     = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
    assign at_a    = (cnt_q == SAMP_A);
    assign at_b    = (cnt_q == HALF);
    assign at_c    = (cnt_q == SAMP_C);
    assign at_end  = (cnt_q == CNT_LAST);
    assign exp_par = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = at_end ? '0 : cnt_q + 16'd1;
        s0_d       = at_a ? sync2_q : s0_q;
        s1_d       = at_b ? sync2_q : s1_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done       = 1'b0;
        frame_ferr = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = S_START;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (at_c && maj) state_d = S_IDLE;
                else if (at_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (at_c) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else bit_d = bit_q + 4'd1;
                end
            end
            S_PARITY: begin
                if (at_c) perr_d = (maj != exp_par);
                if (at_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Final stop bit completes at its centre so the next start edge is caught early
                if (at_c) begin
                    if (!maj) ferr_d = 1'b1;
                    if (stop_q == LAST_STOP) begin
                        done       = 1'b1;
                        frame_ferr = ferr_q | ~maj;
                        state_d    = S_IDLE;
                    end
                end
                if (at_end) stop_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        operr_d = operr_q;
        oferr_d = oferr_q;
        ovr_d   = 1'b0;
        if (done) begin
            if (!valid_q || rx_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
                operr_d = perr_q;
                oferr_d = frame_ferr;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            operr_q <= operr_d;
            oferr_q <= oferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign rx_valid      = valid_q;
    assign rx_data       = data_q;
    assign rx_parity_err = operr_q;
    assign rx_frame_err  = oferr_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 8E1, 7O2) at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rxd = '1;
    logic [2:0] rdy = '1;

    logic       v0, pe0, fe0, ov0, bz0;
    logic [7:0] d0;
    logic       v1, pe1, fe1, ov1, bz1;
    logic [7:0] d1;
    logic       v2, pe2, fe2, ov2, bz2;
    logic [6:0] d2;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ovr_cnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .rx_ready(rdy[0]), .rx_valid(v0), .rx_data(d0),
        .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_overrun(ov0), .rx_busy(bz0));

    uart_rx_cfg #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .rx_ready(rdy[1]), .rx_valid(v1), .rx_data(d1),
        .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_overrun(ov1), .rx_busy(bz1));

    uart_rx_cfg #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[2]), .rx_ready(rdy[2]), .rx_valid(v2), .rx_data(d2),
        .rx_parity_err(pe2), .rx_frame_err(fe2), .rx_overrun(ov2), .rx_busy(bz2));

    function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_word(input int k, input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        logic got;
        got = 1'b0;
        e   = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL word_dut%0d: got unexpected word %0h (pe=%0b fe=%0b), expected none", k, d, p, f);
        end else begin
            chk($sformatf("word_dut%0d {data,pe,fe}", k), 32'({d, p, f}), 32'({e.d, e.pe, e.fe}));
        end
    endtask

    // Monitor: compares every accepted word against the scoreboard and tallies overrun pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (v0 && rdy[0]) mon_word(0, {1'b0, d0}, pe0, fe0);
            if (v1 && rdy[1]) mon_word(1, {1'b0, d1}, pe1, fe1);
            if (v2 && rdy[2]) mon_word(2, {2'b0, d2}, pe2, fe2);
            if (ov0) ovr_cnt[0]++;
            if (ov1) ovr_cnt[1]++;
            if (ov2) ovr_cnt[2]++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gbit >= 0 inverts one clock at the centre of that data bit
    task automatic send(input int k, input logic [8:0] d, input int nb, input int has_par, input logic pbit,
                        input int nstop, input logic [1:0] stopv, input int gbit);
        logic [12:0] bits;
        int n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < nb; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (has_par != 0) begin
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[n] = stopv[i];
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < 10; c++) begin
                rxd[k] = (b == gbit + 1 && c == 6) ? ~bits[b] : bits[b];
                step(1);
            end
        end
        rxd[k] = 1'b1;
        step(6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(3);
        chk("reset_dut0", 32'({v0, pe0, fe0, ov0, bz0, d0}), 32'h0);
        chk("reset_dut1", 32'({v1, pe1, fe1, ov1, bz1, d1}), 32'h0);
        chk("reset_dut2", 32'({v2, pe2, fe2, ov2, bz2, d2}), 32'h0);
        rst_n = 1'b1;
        step(3);

        // 8N1 basic word
        q0.push_back(mk(9'h0A5, 1'b0, 1'b0));
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, -1);
        chk("idle_after_a5 {valid,busy}", 32'({v0, bz0}), 32'h0);

        // Even parity: bad then good parity bit
        q1.push_back(mk(9'h003, 1'b1, 1'b0));
        send(1, 9'h003, 8, 1, 1'b1, 1, 2'b11, -1);
        q1.push_back(mk(9'h003, 1'b0, 1'b0));
        send(1, 9'h003, 8, 1, 1'b0, 1, 2'b11, -1);

        // Framing error then clean frame
        q0.push_back(mk(9'h03C, 1'b0, 1'b1));
        send(0, 9'h03C, 8, 0, 1'b0, 1, 2'b00, -1);
        q0.push_back(mk(9'h081, 1'b0, 1'b0));
        send(0, 9'h081, 8, 0, 1'b0, 1, 2'b11, -1);

        // False start: two low clocks only
        rxd[0] = 1'b0;
        step(2);
        rxd[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("false_start busy early", 32'(bz0), 32'h1);
        repeat (4) @(negedge clk);
        chk("false_start busy at count6", 32'(bz0), 32'h1);
        repeat (1) @(negedge clk);
        chk("false_start busy after count6", 32'(bz0), 32'h0);
        @(posedge clk);
        #1;
        step(10);

        // Single-clock glitch inside data bit 3 is voted out
        q0.push_back(mk(9'h0FF, 1'b0, 1'b0));
        send(0, 9'h0FF, 8, 0, 1'b0, 1, 2'b11, 3);

        // Overrun: second frame dropped while first is held
        rdy[0] = 1'b0;
        q0.push_back(mk(9'h011, 1'b0, 1'b0));
        send(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, -1);
        send(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, -1);
        chk("overrun pulse count", 32'(ovr_cnt[0]), 32'd1);
        chk("overrun held {valid,data}", 32'({v0, d0}), 32'h111);
        rdy[0] = 1'b1;
        step(3);
        chk("overrun drained valid", 32'(v0), 32'h0);

        // 7O2: clean, then bad second stop bit held unaccepted, then reset mid-data
        q2.push_back(mk(9'h055, 1'b0, 1'b0));
        send(2, 9'h055, 7, 1, 1'b1, 2, 2'b11, -1);
        rdy[2] = 1'b0;
        send(2, 9'h055, 7, 1, 1'b1, 2, 2'b01, -1);
        chk("7o2 stop2 err {valid,fe,pe,data}", 32'({v2, fe2, pe2, d2}), 32'({1'b1, 1'b1, 1'b0, 7'h55}));
        rxd[2] = 1'b0;
        step(10);
        rxd[2] = 1'b1;
        step(10);
        rxd[2] = 1'b0;
        step(5);
        rst_n = 1'b0;
        #2;
        chk("midframe_reset outputs", 32'({v2, pe2, fe2, ov2, bz2, d2}), 32'h0);
        rxd[2] = 1'b1;
        step(4);
        rst_n = 1'b1;
        rdy[2] = 1'b1;
        step(4);
        q2.push_back(mk(9'h02A, 1'b0, 1'b0));
        send(2, 9'h02A, 7, 1, 1'b0, 2, 2'b11, -1);

        step(20);
        chk("leftover_dut0", 32'(q0.size()), 32'h0);
        chk("leftover_dut1", 32'(q1.size()), 32'h0);
        chk("leftover_dut2", 32'(q2.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
